// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand-forwarding select and decode-stage hazard control
// for an in-order pipeline with a single non-pipelined multi-cycle unit.
// Forwarding is purely combinational. Stalls come from a one-cycle load-use
// window and from a countdown scoreboard that covers the multi-cycle unit.
module fwd_hazard_ctrl #(
    parameter int AW     = 5,   // register address width
    parameter int NSRC   = 2,   // number of source-operand ports
    parameter int MC_LAT = 4    // multi-cycle op latency, 2..15
) (
    input  logic                 clk,
    input  logic                 rst,

    // Decode stage
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_src,
    input  logic [NSRC-1:0]      id_src_used,
    input  logic [AW-1:0]        id_dst,
    input  logic                 id_regwrite,
    input  logic                 id_is_load,
    input  logic                 id_is_mc,

    // Execute stage sources
    input  logic [NSRC*AW-1:0]   ex_src,
    input  logic [NSRC-1:0]      ex_src_used,

    // Later-stage destinations
    input  logic [AW-1:0]        ex_mem_rd,
    input  logic                 ex_mem_regwrite,
    input  logic [AW-1:0]        mem_wb_rd,
    input  logic                 mem_wb_regwrite,

    output logic [NSRC*2-1:0]    fwd_sel,
    output logic                 stall,
    output logic                 mc_busy
);

    localparam logic [3:0] MC_LAT_C = 4'(MC_LAT);

    // Hazard state
    logic            r_ld_pending;
    logic [AW-1:0]   r_ld_rd;
    logic [3:0]      r_mc_cnt;
    logic [AW-1:0]   r_mc_rd;

    // Decode-side comparison results
    logic            w_ld_hit;
    logic            w_mc_raw;
    logic            w_mc_waw;
    logic            w_ld_stall;
    logic            w_mc_stall;
    logic            w_accept;
    logic            w_accept_ld;
    logic            w_accept_mc;

    // Per-port forward select; EX/MEM wins over MEM/WB, register 0 never forwards
    always_comb begin
        // NOTE: assign a default before any conditional path so no latch is inferred.
        fwd_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (ex_src_used[i] && (ex_src[i*AW +: AW] != '0)) begin
                if (ex_mem_regwrite && (ex_mem_rd == ex_src[i*AW +: AW]))
                    fwd_sel[i*2 +: 2] = 2'b01;
                else if (mem_wb_regwrite && (mem_wb_rd == ex_src[i*AW +: AW]))
                    fwd_sel[i*2 +: 2] = 2'b10;
            end
        end
    end

    // Compare each used decode source against the pending load and mc destinations
    always_comb begin
        w_ld_hit = 1'b0;
        w_mc_raw = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (id_src_used[i]) begin
                if (id_src[i*AW +: AW] == r_ld_rd) w_ld_hit = 1'b1;
                if (id_src[i*AW +: AW] == r_mc_rd) w_mc_raw = 1'b1;
            end
        end
    end

    // A zero destination in either tracker means "nothing to wait for",
    // which also keeps register 0 out of every stall term.
    assign w_mc_waw   = id_regwrite && (id_dst == r_mc_rd);
    assign mc_busy    = (r_mc_cnt != 4'd0);

    assign w_ld_stall = id_valid && r_ld_pending && (r_ld_rd != '0) && w_ld_hit;
    assign w_mc_stall = id_valid && mc_busy &&
                        (id_is_mc || ((r_mc_rd != '0) && (w_mc_raw || w_mc_waw)));
    assign stall      = w_ld_stall || w_mc_stall;

    // An instruction that is both load and mc is handled as mc only
    assign w_accept    = id_valid && !stall;
    assign w_accept_mc = w_accept && id_is_mc;
    assign w_accept_ld = w_accept && id_is_load && id_regwrite && !id_is_mc;

    // Load tracker: open a one-cycle load-use window after an accepted load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ld_pending <= 1'b0;
            r_ld_rd      <= '0;
        end else begin
            // NOTE: non-blocking so every register here samples pre-edge values.
            r_ld_pending <= w_accept_ld;
            if (w_accept_ld)
                r_ld_rd <= id_dst;
        end
    end

    // Multi-cycle scoreboard: load latency on issue, count down every cycle
    // (including stalled ones); result is written back on the 1->0 edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mc_cnt <= 4'd0;
            r_mc_rd  <= '0;
        end else if (w_accept_mc) begin
            r_mc_cnt <= MC_LAT_C;
            r_mc_rd  <= id_regwrite ? id_dst : '0;
        end else if (r_mc_cnt != 4'd0) begin
            r_mc_cnt <= r_mc_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed scenarios plus randomized traffic, checked
// against a cycle-indexed reference model of the hazard rules.
module tb_fwd_hazard_ctrl;

    localparam int AW     = 5;
    localparam int NSRC   = 2;
    localparam int MC_LAT = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                id_valid;
    logic [NSRC*AW-1:0]  id_src;
    logic [NSRC-1:0]     id_src_used;
    logic [AW-1:0]       id_dst;
    logic                id_regwrite;
    logic                id_is_load;
    logic                id_is_mc;
    logic [NSRC*AW-1:0]  ex_src;
    logic [NSRC-1:0]     ex_src_used;
    logic [AW-1:0]       ex_mem_rd;
    logic                ex_mem_regwrite;
    logic [AW-1:0]       mem_wb_rd;
    logic                mem_wb_regwrite;
    logic [NSRC*2-1:0]   fwd_sel;
    logic                stall;
    logic                mc_busy;

    int n_checks = 0;
    int n_errors = 0;

    // Observed outputs from the most recent tick
    logic [NSRC*2-1:0]   obs_fwd;
    logic                obs_stall;
    logic                obs_busy;

    // Reference model: events are remembered by the cycle index they happened on
    int cyc;          // index of the cycle currently being evaluated
    int ld_cycle;     // cycle on which the last load was accepted
    int ld_reg;       // its destination
    int mc_free_at;   // first cycle on which the mc unit is free again
    int mc_reg;       // destination of the mc op in flight (0 if none)

    fwd_hazard_ctrl #(.AW(AW), .NSRC(NSRC), .MC_LAT(MC_LAT)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_src          (id_src),
        .id_src_used     (id_src_used),
        .id_dst          (id_dst),
        .id_regwrite     (id_regwrite),
        .id_is_load      (id_is_load),
        .id_is_mc        (id_is_mc),
        .ex_src          (ex_src),
        .ex_src_used     (ex_src_used),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_regwrite (ex_mem_regwrite),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_regwrite (mem_wb_regwrite),
        .fwd_sel         (fwd_sel),
        .stall           (stall),
        .mc_busy         (mc_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic m_busy();
        return cyc < mc_free_at;
    endfunction

    function automatic logic m_stall();
        logic s;
        logic [AW-1:0] r;
        s = 1'b0;
        if (!id_valid) return 1'b0;
        for (int p = 0; p < NSRC; p++) begin
            r = id_src[p*AW +: AW];
            if (id_src_used[p] && r != 0) begin
                if (cyc == ld_cycle + 1 && int'(r) == ld_reg) s = 1'b1;
                if (m_busy() && int'(r) == mc_reg) s = 1'b1;
            end
        end
        if (m_busy() && id_is_mc) s = 1'b1;
        if (m_busy() && id_regwrite && id_dst != 0 && int'(id_dst) == mc_reg) s = 1'b1;
        return s;
    endfunction

    function automatic logic [1:0] m_fwd(input int p);
        logic [AW-1:0] r;
        r = ex_src[p*AW +: AW];
        if (!ex_src_used[p] || r == 0) return 2'b00;
        if (ex_mem_regwrite && ex_mem_rd == r) return 2'b01;
        if (mem_wb_regwrite && mem_wb_rd == r) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        ld_cycle   = -10;
        ld_reg     = 0;
        mc_free_at = 0;
        mc_reg     = 0;
    endtask

    task automatic model_edge();
        logic acc;
        acc = id_valid && !m_stall();
        if (acc && id_is_mc) begin
            mc_free_at = cyc + 1 + MC_LAT;
            mc_reg     = id_regwrite ? int'(id_dst) : 0;
        end else if (acc && id_is_load && id_regwrite) begin
            ld_cycle = cyc;
            ld_reg   = int'(id_dst);
        end
        cyc++;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        id_valid = 0; id_src = '0; id_src_used = '0; id_dst = '0;
        id_regwrite = 0; id_is_load = 0; id_is_mc = 0;
        ex_src = '0; ex_src_used = '0; ex_mem_rd = '0; ex_mem_regwrite = 0;
        mem_wb_rd = '0; mem_wb_regwrite = 0;
    endtask

    task automatic set_id(input logic v, input int s0, input logic u0, input int s1,
                          input logic u1, input int dst, input logic rw,
                          input logic ld, input logic mc);
        id_valid = v;
        id_src[0 +: AW]  = AW'(s0);
        id_src[AW +: AW] = AW'(s1);
        id_src_used = {u1, u0};
        id_dst = AW'(dst);
        id_regwrite = rw; id_is_load = ld; id_is_mc = mc;
    endtask

    // Called right after a falling edge with inputs already applied.
    task automatic tick(input string tag);
        #1;
        obs_fwd   = fwd_sel;
        obs_stall = stall;
        obs_busy  = mc_busy;
        check({tag, "_stall"}, 32'(obs_stall), 32'(m_stall()));
        check({tag, "_busy"},  32'(obs_busy),  32'(m_busy()));
        for (int p = 0; p < NSRC; p++)
            check({tag, "_fwd"}, 32'(obs_fwd[p*2 +: 2]), 32'(m_fwd(p)));
        model_edge();
        @(negedge clk);
    endtask

    // Tick until stall drops (bounded); returns the number of stalled cycles.
    task automatic count_stall(input string tag, output int n);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            tick(tag);
            if (!obs_stall) break;
            n++;
        end
    endtask

    function automatic logic [AW-1:0] rnd_reg();
        if ($urandom_range(0, 3) == 0) return AW'($urandom);
        return AW'($urandom_range(0, 5));
    endfunction

    task automatic randomize_inputs();
        id_valid    = ($urandom_range(0, 9) < 8);
        for (int p = 0; p < NSRC; p++) begin
            id_src[p*AW +: AW] = rnd_reg();
            ex_src[p*AW +: AW] = rnd_reg();
        end
        id_src_used     = NSRC'($urandom);
        ex_src_used     = NSRC'($urandom);
        id_dst          = rnd_reg();
        id_regwrite     = ($urandom_range(0, 9) < 8);
        id_is_load      = ($urandom_range(0, 9) < 3);
        id_is_mc        = ($urandom_range(0, 19) < 3);
        ex_mem_rd       = rnd_reg();
        ex_mem_regwrite = 1'($urandom);
        mem_wb_rd       = rnd_reg();
        mem_wb_regwrite = 1'($urandom);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        cyc = 0;
        model_reset();
        rst = 1'b1;
        idle_inputs();

        // Reset: outputs idle, forwarding still live
        @(negedge clk);
        id_valid = 1; id_is_mc = 1;
        ex_src[0 +: AW] = AW'(3); ex_src_used = 2'b01;
        ex_mem_rd = AW'(3); ex_mem_regwrite = 1;
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_busy",  32'(mc_busy), 32'd0);
        check("rst_fwd",   32'(fwd_sel), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();

        // Forwarding priority and register 0
        ex_src[0 +: AW] = AW'(3); ex_src[AW +: AW] = AW'(3); ex_src_used = 2'b01;
        ex_mem_rd = AW'(3); ex_mem_regwrite = 1; mem_wb_rd = AW'(3); mem_wb_regwrite = 1;
        tick("fwd_both");
        check("fwd_exmem", 32'(obs_fwd), 32'h1);
        ex_mem_regwrite = 0;
        tick("fwd_wb");
        check("fwd_memwb", 32'(obs_fwd), 32'h2);
        ex_src[0 +: AW] = '0; ex_mem_rd = '0; mem_wb_rd = '0;
        ex_mem_regwrite = 1; mem_wb_regwrite = 1;
        tick("fwd_r0");
        check("fwd_zero", 32'(obs_fwd), 32'h0);
        idle_inputs();

        // Load-use: exactly one stall cycle
        set_id(1, 1, 1, 2, 1, 5, 1, 1, 0);
        tick("ld_issue");
        check("ld_accept", 32'(obs_stall), 32'd0);
        set_id(1, 0, 0, 5, 1, 6, 1, 0, 0);
        tick("ld_use1");
        check("ld_use_stall", 32'(obs_stall), 32'd1);
        tick("ld_use2");
        check("ld_use_release", 32'(obs_stall), 32'd0);
        idle_inputs();
        tick("ld_idle");

        // MC RAW: stall MC_LAT cycles, busy drops with it
        set_id(1, 1, 1, 2, 1, 7, 1, 0, 1);
        tick("mc_issue");
        check("mc_accept", 32'(obs_stall), 32'd0);
        set_id(1, 7, 1, 0, 0, 8, 1, 0, 0);
        count_stall("mc_raw", n);
        check("mc_raw_len", 32'(n), 32'(MC_LAT));
        check("mc_raw_busy_end", 32'(obs_busy), 32'd0);
        idle_inputs();

        // MC structural, then unrelated reader while busy
        set_id(1, 1, 1, 2, 1, 7, 1, 0, 1);
        tick("mc2_issue");
        set_id(1, 10, 1, 11, 1, 12, 1, 0, 1);
        count_stall("mc_struct", n);
        check("mc_struct_len", 32'(n), 32'(MC_LAT));
        set_id(1, 9, 1, 0, 0, 13, 1, 0, 0);
        tick("mc_unrel");
        check("mc_unrel_nostall", 32'(obs_stall), 32'd0);
        check("mc_unrel_busy", 32'(obs_busy), 32'd1);
        idle_inputs();
        repeat (MC_LAT + 1) tick("drain1");

        // Load to r0, then read r0: no stall
        set_id(1, 1, 1, 2, 1, 0, 1, 1, 0);
        tick("ld0_issue");
        set_id(1, 0, 1, 0, 1, 3, 1, 0, 0);
        tick("ld0_use");
        check("ld0_nostall", 32'(obs_stall), 32'd0);

        // MC with regwrite=0: only structural stall
        set_id(1, 1, 1, 2, 1, 7, 0, 0, 1);
        tick("mcnw_issue");
        set_id(1, 7, 1, 7, 1, 7, 1, 0, 0);
        tick("mcnw_dep");
        check("mcnw_nostall", 32'(obs_stall), 32'd0);
        set_id(1, 1, 1, 2, 1, 4, 1, 0, 1);
        tick("mcnw_struct");
        check("mcnw_struct_stall", 32'(obs_stall), 32'd1);
        idle_inputs();
        repeat (MC_LAT + 1) tick("drain2");

        // Reset in the middle of a countdown
        set_id(1, 1, 1, 2, 1, 7, 1, 0, 1);
        tick("rmc_issue");
        idle_inputs();
        tick("rmc_w1");
        tick("rmc_w2");
        set_id(1, 7, 1, 0, 0, 8, 1, 0, 0);
        #1;
        check("rmc_pre_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        check("rmc_busy", 32'(mc_busy), 32'd0);
        check("rmc_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick("rmc_after");
        check("rmc_accept", 32'(obs_stall), 32'd0);
        idle_inputs();

        // Randomized traffic with occasional asynchronous reset
        for (int i = 0; i < 600; i++) begin
            randomize_inputs();
            if ($urandom_range(0, 99) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                model_reset();
                check("rnd_rst_busy",  32'(mc_busy), 32'(m_busy()));
                check("rnd_rst_stall", 32'(stall),   32'(m_stall()));
                check("rnd_rst_fwd",   32'(fwd_sel[1:0]), 32'(m_fwd(0)));
                @(negedge clk);
                rst = 1'b0;
            end else begin
                tick("rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter AW, default 5: register address width.
REQ-002 The block SHALL have parameter NSRC, default 2: number of source-operand ports.
REQ-003 The block SHALL have parameter MC_LAT, default 4, legal range 2..15: multi-cycle op latency in cycles.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port id_valid, input, 1 bit: decode stage holds a valid instruction.
REQ-007 Ports id_src (input, NSRC*AW) and id_src_used (input, NSRC): decode source registers, port i at [i*AW +: AW], plus per-port use flags.
REQ-008 Ports id_dst (input, AW), id_regwrite, id_is_load and id_is_mc (input, 1 bit each): decode destination, register-write flag, load flag and multi-cycle-op flag.
REQ-009 Ports ex_src (input, NSRC*AW) and ex_src_used (input, NSRC): source registers and use flags of the EX-stage instruction.
REQ-010 Ports ex_mem_rd (input, AW) and ex_mem_regwrite (input, 1): EX/MEM destination register and write flag.
REQ-011 Ports mem_wb_rd (input, AW) and mem_wb_regwrite (input, 1): MEM/WB destination register and write flag.
REQ-012 Port fwd_sel, output, NSRC*2 bits: per-port forward select, 00 = register file, 01 = EX/MEM, 10 = MEM/WB.
REQ-013 Port stall, output, 1 bit: hold the decode instruction and insert a bubble into EX.
REQ-014 Port mc_busy, output, 1 bit: the multi-cycle unit is occupied.

Function
REQ-015 fwd_sel SHALL be combinational: for each port with ex_src_used=1, select 01 if ex_mem_regwrite=1 and ex_mem_rd=ex_src; else 10 if mem_wb_regwrite=1 and mem_wb_rd=ex_src; else 00.
REQ-016 EX/MEM SHALL take priority over MEM/WB when both match.
REQ-017 A source of register 0 SHALL never forward and SHALL never cause a stall.
REQ-018 An unused port (src_used=0) SHALL select 00 and SHALL never cause a stall.
REQ-019 The decode instruction SHALL be accepted on a cycle with id_valid=1 and stall=0.
REQ-020 Load tracking: on acceptance with id_is_load=1 and id_regwrite=1, ld_pending SHALL be set to 1 and ld_rd to id_dst at the next edge; on any other cycle ld_pending SHALL clear to 0.
REQ-021 Load-use stall: stall SHALL be 1 when id_valid=1, ld_pending=1, ld_rd is nonzero, and any used decode source equals ld_rd.
REQ-022 A load-use stall SHALL be exactly one cycle, because the bubble clears ld_pending.
REQ-023 Multi-cycle scoreboard: on acceptance with id_is_mc=1, the 4-bit counter mc_cnt SHALL load MC_LAT and mc_rd SHALL load id_dst (0 when id_regwrite=0).
REQ-024 While mc_cnt is nonzero, mc_cnt SHALL decrement by 1 each cycle.
REQ-025 mc_busy SHALL equal (mc_cnt != 0).
REQ-026 MC stall: stall SHALL be 1 when id_valid=1, mc_busy=1, and any of the following holds:
- a used decode source equals mc_rd and mc_rd is nonzero (RAW);
- id_regwrite=1 and id_dst equals mc_rd and mc_rd is nonzero (WAW);
- id_is_mc=1 (structural).
REQ-027 The mc result SHALL be treated as written back on the edge where mc_cnt goes 1->0; a dependent decode instruction SHALL be accepted on the following cycle.
REQ-028 stall SHALL be the OR of the load-use and MC stall terms; with id_valid=0, stall SHALL be 0.
REQ-029 An instruction that is both load and mc SHALL be treated as mc only.
REQ-030 A stalled instruction SHALL cause no state update: no ld_pending set and no mc_cnt load.
REQ-031 mc_cnt SHALL still decrement while stall=1.

Reset
REQ-032 On rst=1, asynchronously: ld_pending=0, ld_rd=0, mc_cnt=0, mc_rd=0.
REQ-033 Consequently, during reset stall=0 and mc_busy=0; fwd_sel follows its inputs combinationally.
REQ-034 Reset asserted mid-operation SHALL abort any mc countdown immediately; the first edge after deassertion SHALL see an idle scoreboard.

Verification
REQ-035 ex_src[0]=3 used, ex_mem_rd=3/wr=1, mem_wb_rd=3/wr=1 -> fwd_sel[1:0]=01; with ex_mem_regwrite=0 -> 10; with ex_src[0]=0 -> 00.
REQ-036 Load to r5 accepted, next decode reads r5 on port 1 -> stall=1 for exactly one cycle, then 0 and the instruction is accepted.
REQ-037 MC op (MC_LAT=4) to r7 accepted, then decode reads r7 -> stall=1 for 4 cycles, mc_busy falls with it, accepted in cycle 5.
REQ-038 MC op busy, decode issues a second mc op with unrelated registers -> stall until mc_busy=0; decode reads an unrelated r9 -> no stall.
REQ-039 Load to r0 followed by a read of r0 -> no stall; MC op with id_regwrite=0 -> only the structural stall applies.
REQ-040 rst pulsed at mc_cnt=2 -> mc_busy=0 and stall=0 immediately, and a dependent read is accepted the first cycle after release.
